sha256_job_arbiter: RTL and testbench

//  Shares one simplified SHA-256 core among NUM_REQ requesters. Round-robin picks one pending job,

---
 rtl/sha_arb_pkg.sv | 18 +
 rtl/sha256_job_arbiter_if.sv | 25 ++
 rtl/sha_rr_picker.sv | 34 +++
 rtl/sha256_job_arbiter.sv | 161 ++++++++++++++++
 tb/tb_sha256_job_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sha_arb_pkg.sv
// Shared types and constants for the SHA-256 job arbiter.
package sha_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_LO,
        WAIT_HI,
        FINISH,
        ABORT
    } arb_state_t;

    localparam int ADDR_W_DEF      = 16;
    localparam int JOB_CNT_W       = 16;
    localparam int WDOG_CNT_W      = 16;
    localparam int CORE_RST_CYCLES = 2;

endpackage

// File: rtl/sha256_job_arbiter_if.sv
// Requester-side job handshake: level request plus addresses in, ack/err pulses out.
interface sha256_job_arbiter_if
    import sha_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = ADDR_W_DEF
);

    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*ADDR_W-1:0] req_msg_addr;
    logic [NUM_REQ*ADDR_W-1:0] req_out_addr;
    logic [NUM_REQ-1:0]        ack;
    logic [NUM_REQ-1:0]        err;

    modport master (
        output req, req_msg_addr, req_out_addr,
        input  ack, err
    );

    modport slave (
        input  req, req_msg_addr, req_out_addr,
        output ack, err
    );

endinterface

// File: rtl/sha_rr_picker.sv
// Combinational round-robin picker: first set request searching upward from ptr+1, wrapping.
module sha_rr_picker #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic                       valid,
    output logic [$clog2(NUM_REQ)-1:0] winner
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic             found;
    int               idx_int;
    logic [IDX_W-1:0] idx;

    // The requester just served sits at ptr, so it is visited last.
    always_comb begin
        valid   = |req;
        winner  = '0;
        found   = 1'b0;
        idx_int = 0;
        idx     = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx_int = (int'(ptr) + k) % NUM_REQ;
            idx     = IDX_W'(idx_int);
            if (!found && req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sha256_job_arbiter.sv
// Round-robin arbiter sharing one SHA-256 core among NUM_REQ requesters.
// Define SHA_ARB_WDOG_EN to add the per-job watchdog with core reset and err reporting.
module sha256_job_arbiter
    import sha_arb_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int WDOG_CYCLES = 4096
) (
    input  logic                       clk,
    input  logic                       reset_n,
    sha256_job_arbiter_if.slave        jobs,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic [JOB_CNT_W-1:0]       jobs_done,
    output logic                       core_start,
    output logic [ADDR_W-1:0]          core_msg_addr,
    output logic [ADDR_W-1:0]          core_out_addr,
    input  logic                       core_done,
    output logic                       core_rst_n
);

    localparam int IDX_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || WDOG_CYCLES < 1 || WDOG_CYCLES > 65536) begin : g_param_check
        $error("sha256_job_arbiter: parameter out of range");
    end

    arb_state_t           state_q, state_d;
    logic [IDX_W-1:0]     grant_q, ptr_q, pick_id;
    logic                 pick_valid, launch, job_aborted;
    logic [ADDR_W-1:0]    msg_q, out_q, pick_msg, pick_out;
    logic [JOB_CNT_W-1:0] jobs_q;
    logic [NUM_REQ-1:0]   ack_vec, err_vec;

    sha_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .req    (jobs.req),
        .ptr    (ptr_q),
        .valid  (pick_valid),
        .winner (pick_id)
    );

    always_comb begin
        pick_msg = '0;
        pick_out = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_id == IDX_W'(i)) begin
                pick_msg = jobs.req_msg_addr[i*ADDR_W +: ADDR_W];
                pick_out = jobs.req_out_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    // Only launch when the core reports idle, otherwise its done edge sequence is meaningless.
    assign launch = (state_q == IDLE) && pick_valid && core_done;

`ifdef SHA_ARB_WDOG_EN
    logic [WDOG_CNT_W-1:0] wdog_q;
    logic [1:0]            abort_cnt_q;
    logic                  aborted_q;
    logic                  wdog_hit, abort_done;

    assign wdog_hit   = (wdog_q == WDOG_CNT_W'(WDOG_CYCLES - 1));
    assign abort_done = (abort_cnt_q == 2'(CORE_RST_CYCLES - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wdog_q      <= '0;
            abort_cnt_q <= '0;
            aborted_q   <= 1'b0;
        end else begin
            case (state_q)
                START: begin
                    wdog_q    <= '0;
                    aborted_q <= 1'b0;
                end
                WAIT_LO, WAIT_HI: begin
                    wdog_q      <= wdog_q + 1'b1;
                    abort_cnt_q <= '0;
                    if (state_d == ABORT) aborted_q <= 1'b1;
                end
                ABORT:   abort_cnt_q <= abort_cnt_q + 1'b1;
                default: ;
            endcase
        end
    end

    assign job_aborted = aborted_q;
    assign core_rst_n  = reset_n & (state_q != ABORT);
`else
    assign job_aborted = 1'b0;
    assign core_rst_n  = reset_n;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (launch) state_d = START;
            START:   state_d = WAIT_LO;
            WAIT_LO: begin
                if (!core_done) state_d = WAIT_HI;
`ifdef SHA_ARB_WDOG_EN
                else if (wdog_hit) state_d = ABORT;
`endif
            end
            WAIT_HI: begin
                if (core_done) state_d = FINISH;
`ifdef SHA_ARB_WDOG_EN
                else if (wdog_hit) state_d = ABORT;
`endif
            end
            FINISH:  state_d = IDLE;
`ifdef SHA_ARB_WDOG_EN
            ABORT:   if (abort_done) state_d = FINISH;
`endif
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ack_vec = '0;
        err_vec = '0;
        if (state_q == FINISH) begin
            ack_vec[grant_q] = 1'b1;
            err_vec[grant_q] = job_aborted;
        end
    end

    // Pointer moves to the served requester even on abort so it cannot monopolise a hung core.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            msg_q   <= '0;
            out_q   <= '0;
            ptr_q   <= IDX_W'(NUM_REQ - 1);
            jobs_q  <= '0;
        end else begin
            state_q <= state_d;
            if (launch) begin
                grant_q <= pick_id;
                msg_q   <= pick_msg;
                out_q   <= pick_out;
            end
            if (state_q == FINISH) begin
                ptr_q <= grant_q;
                if (!job_aborted) jobs_q <= jobs_q + 1'b1;
            end
        end
    end

    assign jobs.ack      = ack_vec;
    assign jobs.err      = err_vec;
    assign busy          = (state_q != IDLE);
    assign core_start    = (state_q == START);
    assign grant_id      = grant_q;
    assign core_msg_addr = msg_q;
    assign core_out_addr = out_q;
    assign jobs_done     = jobs_q;

endmodule

// File: tb/tb_sha256_job_arbiter.sv
// Scoreboard bench for sha256_job_arbiter with a behavioural core (done low 1 cycle after start, high 300 later).
// With SHA_ARB_WDOG_EN defined it also exercises the watchdog abort path.
module tb_sha256_job_arbiter;

    localparam int NUM_REQ  = 4;
    localparam int ADDR_W   = 16;
    localparam int CORE_LAT = 300;
    localparam int ACK_WAIT = 1000;
`ifdef SHA_ARB_WDOG_EN
    localparam int WDOG = 100;
`else
    localparam int WDOG = 4096;
`endif

    typedef struct packed {
        logic [1:0]  id;
        logic [15:0] msg;
        logic [15:0] out;
    } start_t;

    typedef struct packed {
        logic [3:0] ack;
        logic [3:0] err;
    } ack_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        busy, core_start, core_done, core_rst_n;
    logic [1:0]  grant_id;
    logic [15:0] jobs_done, core_msg_addr, core_out_addr;

    sha256_job_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W)) jobs ();

    sha256_job_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .ADDR_W      (ADDR_W),
        .WDOG_CYCLES (WDOG)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .jobs          (jobs),
        .busy          (busy),
        .grant_id      (grant_id),
        .jobs_done     (jobs_done),
        .core_start    (core_start),
        .core_msg_addr (core_msg_addr),
        .core_out_addr (core_out_addr),
        .core_done     (core_done),
        .core_rst_n    (core_rst_n)
    );

    always #5 clk = ~clk;

    start_t     start_q[$];
    ack_t       ack_q[$];
    start_t     se;
    ack_t       ae;
    int         tests = 0;
    int         failed = 0;
    int         rst_low_cnt = 0;
    logic       core_busy = 1'b0;
    int         core_cnt = 0;
    logic       force_low = 1'b0;
    logic       hang = 1'b0;
    logic       done_p1 = 1'b1;
    logic       done_p2 = 1'b1;
    logic [3:0] ack_p = 4'b0;

    // Behavioural core: leaves idle the cycle after start and returns CORE_LAT cycles later.
    always @(posedge clk) begin
        if (!core_rst_n) begin
            core_busy <= 1'b0;
            core_cnt  <= 0;
        end else if (core_start) begin
            core_busy <= 1'b1;
            core_cnt  <= 0;
        end else if (core_busy) begin
            if (core_cnt >= CORE_LAT - 1 && !hang) core_busy <= 1'b0;
            else core_cnt <= core_cnt + 1;
        end
    end

    assign core_done = ~core_busy & ~force_low;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic flagFail(input string name, input string why);
        tests++;
        failed++;
        $display("[TB] FAIL %s: %s", name, why);
    endtask

    task automatic applyStimulus(input logic [3:0] req_v);
        jobs.req = req_v;
    endtask

    task automatic setAddr(input int i, input logic [15:0] msg, input logic [15:0] out);
        jobs.req_msg_addr[i*16 +: 16] = msg;
        jobs.req_out_addr[i*16 +: 16] = out;
    endtask

    task automatic defaultAddrs();
        for (int i = 0; i < NUM_REQ; i++) setAddr(i, 16'h1000 + 16'(i), 16'h2000 + 16'(i));
    endtask

    task automatic expectStart(input logic [1:0] id, input logic [15:0] msg, input logic [15:0] out);
        start_q.push_back(start_t'{id: id, msg: msg, out: out});
    endtask

    task automatic expectAck(input logic [3:0] a, input logic [3:0] e);
        ack_q.push_back(ack_t'{ack: a, err: e});
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic waitAck(input int idx, input bit drop_req);
        int n = 0;
        while (n < ACK_WAIT) begin
            @(negedge clk);
            if (jobs.ack[idx]) break;
            n++;
        end
        if (!jobs.ack[idx])
            flagFail($sformatf("ack%0d_wait", idx), $sformatf("ack=0x%0h after %0d cycles, expected ack[%0d]=1", jobs.ack, ACK_WAIT, idx));
        else if (drop_req)
            jobs.req[idx] = 1'b0;
    endtask

    task automatic doReset();
        reset_n = 1'b0;
        waitCycles(2);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    // Monitor: every launch and every ack is matched against the next queued expectation.
    always @(negedge clk) begin
        if (reset_n) begin
            if (core_start) begin
                if (start_q.size() == 0) begin
                    flagFail("start_unexpected", $sformatf("core_start=1 grant_id=%0d, expected no launch", grant_id));
                end else begin
                    se = start_q.pop_front();
                    checkOutput("start_grant_id", 32'(grant_id), 32'(se.id));
                    checkOutput("start_msg_addr", 32'(core_msg_addr), 32'(se.msg));
                    checkOutput("start_out_addr", 32'(core_out_addr), 32'(se.out));
                end
            end
            if (ack_p != 4'b0) checkOutput("ack_single_cycle", 32'(jobs.ack), 32'h0);
            if (jobs.ack != 4'b0) begin
                if (ack_q.size() == 0) begin
                    flagFail("ack_unexpected", $sformatf("ack=0x%0h, expected no ack", jobs.ack));
                end else begin
                    ae = ack_q.pop_front();
                    checkOutput("ack_vector", 32'(jobs.ack), 32'(ae.ack));
                    checkOutput("err_vector", 32'(jobs.err), 32'(ae.err));
                    if (ae.err == 4'b0) checkOutput("ack_latency", {30'b0, done_p2, done_p1}, 32'h1);
                end
            end else if (jobs.err != 4'b0) begin
                flagFail("err_without_ack", $sformatf("err=0x%0h with ack=0, expected err=0", jobs.err));
            end
            if (!core_rst_n) rst_low_cnt++;
        end
        ack_p   = jobs.ack;
        done_p2 = done_p1;
        done_p1 = core_done;
    end

    initial begin
        #500000;
        flagFail("global_timeout", "simulation time limit reached, expected bench completion");
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        jobs.req          = '0;
        jobs.req_msg_addr = '0;
        jobs.req_out_addr = '0;
        defaultAddrs();
        reset_n = 1'b0;
        waitCycles(3);
        checkOutput("reset_busy", 32'(busy), 32'h0);
        checkOutput("reset_ack", 32'(jobs.ack), 32'h0);
        checkOutput("reset_err", 32'(jobs.err), 32'h0);
        checkOutput("reset_core_start", 32'(core_start), 32'h0);
        checkOutput("reset_grant_id", 32'(grant_id), 32'h0);
        checkOutput("reset_core_msg_addr", 32'(core_msg_addr), 32'h0);
        checkOutput("reset_core_out_addr", 32'(core_out_addr), 32'h0);
        checkOutput("reset_jobs_done", 32'(jobs_done), 32'h0);
        checkOutput("reset_core_rst_n", 32'(core_rst_n), 32'h0);
        reset_n = 1'b1;
        @(negedge clk);
        checkOutput("run_core_rst_n", 32'(core_rst_n), 32'h1);

        $display("[TB] single request from requester 2");
        setAddr(2, 16'h0100, 16'h0200);
        expectStart(2'd2, 16'h0100, 16'h0200);
        expectAck(4'b0100, 4'b0000);
        applyStimulus(4'b0100);
        @(negedge clk);
        checkOutput("t1_start_latency", 32'(core_start), 32'h1);
        setAddr(2, 16'hDEAD, 16'hBEEF);
        waitCycles(5);
        checkOutput("t1_msg_addr_held", 32'(core_msg_addr), 32'h0100);
        checkOutput("t1_out_addr_held", 32'(core_out_addr), 32'h0200);
        checkOutput("t1_busy", 32'(busy), 32'h1);
        waitAck(2, 1'b1);
        @(negedge clk);
        checkOutput("t1_jobs_done", 32'(jobs_done), 32'h1);

        $display("[TB] all four requesters held");
        doReset();
        defaultAddrs();
        expectStart(2'd0, 16'h1000, 16'h2000); expectAck(4'b0001, 4'b0000);
        expectStart(2'd1, 16'h1001, 16'h2001); expectAck(4'b0010, 4'b0000);
        expectStart(2'd2, 16'h1002, 16'h2002); expectAck(4'b0100, 4'b0000);
        expectStart(2'd3, 16'h1003, 16'h2003); expectAck(4'b1000, 4'b0000);
        expectStart(2'd0, 16'h1000, 16'h2000); expectAck(4'b0001, 4'b0000);
        applyStimulus(4'b1111);
        waitAck(0, 1'b0);
        waitAck(1, 1'b0);
        waitAck(2, 1'b0);
        waitAck(3, 1'b0);
        waitAck(0, 1'b0);
        applyStimulus(4'b0000);
        @(negedge clk);
        checkOutput("t2_jobs_done", 32'(jobs_done), 32'h5);

        $display("[TB] requester 1 drops its request mid-job");
        expectStart(2'd1, 16'h1001, 16'h2001);
        expectAck(4'b0010, 4'b0000);
        applyStimulus(4'b0010);
        waitCycles(10);
        checkOutput("t3_core_done_low", 32'(core_done), 32'h0);
        applyStimulus(4'b0000);
        waitAck(1, 1'b0);
        waitCycles(20);
        checkOutput("t3_no_relaunch", 32'(busy), 32'h0);
        checkOutput("t3_jobs_done", 32'(jobs_done), 32'h6);

        $display("[TB] core not idle at request time");
        force_low = 1'b1;
        applyStimulus(4'b0001);
        waitCycles(20);
        checkOutput("t4_held_off", 32'(busy), 32'h0);
        expectStart(2'd0, 16'h1000, 16'h2000);
        expectAck(4'b0001, 4'b0000);
        force_low = 1'b0;
        @(negedge clk);
        checkOutput("t4_start_after_done", 32'(core_start), 32'h1);
        waitAck(0, 1'b1);
        @(negedge clk);
        checkOutput("t4_jobs_done", 32'(jobs_done), 32'h7);

        $display("[TB] reset in the middle of a job");
        expectStart(2'd1, 16'h1001, 16'h2001);
        applyStimulus(4'b0010);
        waitCycles(50);
        reset_n = 1'b0;
        applyStimulus(4'b0000);
        #1;
        checkOutput("t5_reset_busy", 32'(busy), 32'h0);
        checkOutput("t5_reset_ack", 32'(jobs.ack), 32'h0);
        checkOutput("t5_reset_jobs_done", 32'(jobs_done), 32'h0);
        waitCycles(2);
        expectStart(2'd3, 16'h1003, 16'h2003);
        expectAck(4'b1000, 4'b0000);
        reset_n = 1'b1;
        applyStimulus(4'b1000);
        @(negedge clk);
        checkOutput("t5_start_after_reset", 32'(core_start), 32'h1);
        waitAck(3, 1'b1);
        @(negedge clk);
        checkOutput("t5_jobs_done", 32'(jobs_done), 32'h1);

`ifdef SHA_ARB_WDOG_EN
        $display("[TB] watchdog abort on a hung core");
        doReset();
        expectStart(2'd0, 16'h1000, 16'h2000); expectAck(4'b0001, 4'b0001);
        expectStart(2'd1, 16'h1001, 16'h2001); expectAck(4'b0010, 4'b0000);
        rst_low_cnt = 0;
        hang = 1'b1;
        applyStimulus(4'b0011);
        waitAck(0, 1'b1);
        hang = 1'b0;
        checkOutput("t6_core_rst_cycles", 32'(rst_low_cnt), 32'h2);
        @(negedge clk);
        checkOutput("t6_jobs_done_after_abort", 32'(jobs_done), 32'h0);
        waitAck(1, 1'b1);
        @(negedge clk);
        checkOutput("t6_jobs_done", 32'(jobs_done), 32'h1);
`endif

        waitCycles(5);
        checkOutput("start_queue_drained", 32'(start_q.size()), 32'h0);
        checkOutput("ack_queue_drained", 32'(ack_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
